// File: rtl/moa_ctrl_pkg.sv
// Shared types and sizing constants for the multi-operand sum controller.
// No logic; imported by the controller and its four-slot adder.
package moa_ctrl_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        ADD     = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam int OP_W      = 4;
    localparam int NUM_SLOTS = 4;
    localparam int SUM4_W    = 7;
    localparam int CNT_W     = 7;

endpackage

// File: rtl/multiple_operand_adder_4x4.sv
// Four-input unsigned adder of 4-bit operands into a 7-bit sum.
// Latency: combinational. Backpressure: none, pure datapath.
module multiple_operand_adder_4x4
    import moa_ctrl_pkg::*;
(
    input  logic [OP_W-1:0]   x,
    input  logic [OP_W-1:0]   y,
    input  logic [OP_W-1:0]   z,
    input  logic [OP_W-1:0]   w,
    output logic [SUM4_W-1:0] sum
);

    assign sum = SUM4_W'(x) + SUM4_W'(y) + SUM4_W'(z) + SUM4_W'(w);

endmodule

// File: rtl/multi_operand_sum_ctrl.sv
// Collects 4-bit operands four slots at a time, accumulates them, and reports sum and count per set.
// Latency: result valid 2 cycles after the terminating operand. Backpressure: in_ready low in ADD/DONE; result held until out_ready.
// Optional MOA_CTRL_STATS_EN: saturating completed-set counter on set_count (constant 0 otherwise).
module multi_operand_sum_ctrl
    import moa_ctrl_pkg::*;
#(
    parameter int MAX_OPS = 16,
    parameter int OUT_W   = 4 + $clog2(MAX_OPS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [OP_W-1:0]   in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              out_valid,
    output logic [OUT_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_cnt,
    input  logic              out_ready,
    output logic [15:0]       set_count
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_OPS - 1);
    localparam logic [1:0]       LAST_IDX = 2'(NUM_SLOTS - 1);

    state_t              r_state;
    logic [OP_W-1:0]     r_slot [NUM_SLOTS];
    logic [1:0]          r_slot_idx;
    logic [CNT_W-1:0]    r_op_cnt;
    logic [OUT_W-1:0]    r_acc;
    logic                r_term;
    logic                r_in_ready;
    logic                r_out_valid;
    logic [OUT_W-1:0]    r_out_sum;
    logic [CNT_W-1:0]    r_out_cnt;

    logic                w_in_hs;
    logic                w_last_op;
    logic                w_end_group;
    logic [SUM4_W-1:0]   w_sum4;
    logic [OUT_W-1:0]    w_acc_next;

    multiple_operand_adder_4x4 u_add4 (
        .x   (r_slot[0]),
        .y   (r_slot[1]),
        .z   (r_slot[2]),
        .w   (r_slot[3]),
        .sum (w_sum4)
    );

    assign w_in_hs     = in_valid && r_in_ready;
    assign w_last_op   = (r_op_cnt == LAST_CNT);
    assign w_end_group = (r_slot_idx == LAST_IDX) || in_last || w_last_op;
    assign w_acc_next  = r_acc + OUT_W'(w_sum4);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= COLLECT;
            r_slot_idx  <= '0;
            r_op_cnt    <= '0;
            r_acc       <= '0;
            r_term      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_cnt   <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) r_slot[i] <= '0;
        end else begin
            unique case (r_state)
                COLLECT: begin
                    if (w_in_hs) begin
                        r_slot[r_slot_idx] <= in_data;
                        r_slot_idx         <= r_slot_idx + 2'd1;
                        r_op_cnt           <= r_op_cnt + 7'd1;
                        // Reaching MAX_OPS ends the set even without in_last.
                        r_term             <= in_last || w_last_op;
                        if (w_end_group) begin
                            r_state    <= ADD;
                            r_in_ready <= 1'b0;
                        end
                    end
                end
                ADD: begin
                    r_acc      <= w_acc_next;
                    r_slot_idx <= '0;
                    for (int i = 0; i < NUM_SLOTS; i++) r_slot[i] <= '0;
                    if (r_term) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                        r_out_sum   <= w_acc_next;
                        r_out_cnt   <= r_op_cnt;
                    end else begin
                        r_state    <= COLLECT;
                        r_in_ready <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state     <= COLLECT;
                        r_acc       <= '0;
                        r_op_cnt    <= '0;
                        r_term      <= 1'b0;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= COLLECT;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_cnt   = r_out_cnt;

`ifdef MOA_CTRL_STATS_EN
    logic        w_out_hs;
    logic [15:0] r_set_count;

    assign w_out_hs = r_out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_set_count <= '0;
        end else if (w_out_hs && (r_set_count != 16'hFFFF)) begin
            r_set_count <= r_set_count + 16'd1;
        end
    end

    assign set_count = r_set_count;
`else
    assign set_count = '0;
`endif

endmodule

// File: tb/tb_multi_operand_sum_ctrl.sv
// Bench for multi_operand_sum_ctrl: directed sets, per-cycle reference model, literal result checks.
// Follows MOA_CTRL_STATS_EN to pick the expected set_count behaviour.
module tb_multi_operand_sum_ctrl;

    localparam int MAX_OPS = 16;
    localparam int OUT_W   = 8;

    logic             clk       = 1'b0;
    logic             rst       = 1'b1;
    logic             in_valid  = 1'b0;
    logic [3:0]       in_data   = '0;
    logic             in_last   = 1'b0;
    logic             out_ready = 1'b1;
    logic             in_ready;
    logic             out_valid;
    logic [OUT_W-1:0] out_sum;
    logic [6:0]       out_cnt;
    logic [15:0]      set_count;

    int tests = 0;
    int fails = 0;

    typedef struct { int sum; int cnt; } res_t;
    res_t obs[$];

    multi_operand_sum_ctrl #(.MAX_OPS(MAX_OPS), .OUT_W(OUT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_sum   (out_sum),
        .out_cnt   (out_cnt),
        .out_ready (out_ready),
        .set_count (set_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail(input string nm);
        tests++;
        fails++;
        $display("FAIL %s: bound expired at %0t", nm, $time);
    endtask

    // Reference model: expected outputs for the current cycle, advanced at each negedge
    // from the inputs that will be seen at the coming rising edge.
    bit chk_en    = 0;
    bit e_in_rdy  = 1;
    bit e_out_vld = 0;
    bit add_now   = 0;
    bit term_pend = 0;
    int e_sum = 0, e_cnt = 0, e_setcnt = 0;
    int p_sum = 0, p_cnt = 0, grp = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", int'(in_ready), int'(e_in_rdy));
            chk("out_valid", int'(out_valid), int'(e_out_vld));
            if (e_out_vld) begin
                chk("out_sum", int'(out_sum), e_sum);
                chk("out_cnt", int'(out_cnt), e_cnt);
            end
            chk("set_count", int'(set_count), e_setcnt);
        end
        if (rst) begin
            chk_en = 1; e_in_rdy = 1; e_out_vld = 0; add_now = 0; term_pend = 0;
            e_sum = 0; e_cnt = 0; e_setcnt = 0; p_sum = 0; p_cnt = 0; grp = 0;
        end else if (chk_en) begin
            if (e_out_vld) begin
                if (out_ready) begin
                    e_out_vld = 0; e_in_rdy = 1; p_sum = 0; p_cnt = 0;
`ifdef MOA_CTRL_STATS_EN
                    if (e_setcnt < 65535) e_setcnt++;
`endif
                end
            end else if (add_now) begin
                add_now = 0;
                if (term_pend) begin
                    e_out_vld = 1; e_sum = p_sum; e_cnt = p_cnt; e_in_rdy = 0;
                end else begin
                    e_in_rdy = 1;
                end
            end else if (e_in_rdy && in_valid) begin
                p_sum += int'(in_data);
                p_cnt++;
                grp++;
                term_pend = in_last || (p_cnt == MAX_OPS);
                if (grp == 4 || term_pend) begin
                    add_now = 1; grp = 0; e_in_rdy = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) obs.push_back('{int'(out_sum), int'(out_cnt)});
    end

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    // Offer one operand and hold it until accepted; returns 1 time unit after the accepting edge.
    task automatic send(input logic [3:0] d, input logic l);
        int n = 0;
        in_valid = 1'b1; in_data = d; in_last = l;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) fail("send_wait");
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_result(input string nm);
        int n = 0;
        int start = obs.size();
        while (obs.size() == start && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (obs.size() == start) fail({nm, "_wait"});
        @(negedge clk);
    endtask

    task automatic check_res(input string nm, input int s, input int c);
        res_t r;
        chk({nm, "_present"}, obs.size(), 1);
        if (obs.size() == 0) return;
        r = obs.pop_front();
        chk({nm, "_sum"}, r.sum, s);
        chk({nm, "_cnt"}, r.cnt, c);
    endtask

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_sum", int'(out_sum), 0);
        chk("rst_out_cnt", int'(out_cnt), 0);
        chk("rst_set_count", int'(set_count), 0);

        // 1,2,3,4 with last on the 4th: exact two-cycle latency, one-cycle pulse
        align();
        send(4'd1, 1'b0); send(4'd2, 1'b0); send(4'd3, 1'b0); send(4'd4, 1'b1);
        @(negedge clk); chk("t1_lat_add", int'(out_valid), 0);
        @(negedge clk); chk("t1_lat_done", int'(out_valid), 1);
        @(negedge clk); chk("t1_single", int'(out_valid), 0);
        check_res("t1", 10, 4);

        // sixteen 0xF without last: forced termination at MAX_OPS
        align();
        for (int i = 0; i < 16; i++) send(4'hF, 1'b0);
        wait_result("t2");
        check_res("t2", 240, 16);

        // single operand with last: unfilled slots contribute zero
        align();
        send(4'hA, 1'b1);
        wait_result("t3");
        check_res("t3", 10, 1);

        // result stalled 5 cycles with a producer holding in_valid high
        align();
        out_ready = 1'b0;
        send(4'd3, 1'b0); send(4'd4, 1'b1);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) fail("t4_wait_valid");
        align();
        in_valid = 1'b1; in_data = 4'd9;
        repeat (5) begin
            @(negedge clk);
            chk("t4_hold_rdy", int'(in_ready), 0);
            chk("t4_hold_vld", int'(out_valid), 1);
            chk("t4_hold_sum", int'(out_sum), 7);
        end
        align();
        in_valid = 1'b0; out_ready = 1'b1;
        wait_result("t4");
        check_res("t4", 7, 2);

        // partial set discarded by reset
        align();
        send(4'd7, 1'b0); send(4'd8, 1'b0);
        align();
        rst = 1'b1;
        align();
        rst = 1'b0;
        send(4'd5, 1'b0); send(4'd5, 1'b1);
        wait_result("t5");
        chk("t5_only_one", obs.size(), 1);
        check_res("t5", 10, 2);

        // set spanning two slot groups, then an exactly-two-group set
        align();
        for (int i = 1; i <= 6; i++) send(4'(i), (i == 6));
        wait_result("t6");
        check_res("t6", 21, 6);
        align();
        for (int i = 1; i <= 8; i++) send(4'd2, (i == 8));
        wait_result("t7");
        check_res("t7", 16, 8);

        @(negedge clk);
`ifdef MOA_CTRL_STATS_EN
        chk("set_count_final", int'(set_count), 3);
`else
        chk("set_count_final", int'(set_count), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
